// File: rtl/pc_pkg.sv
// Shared types for the fetch PC generator: next-PC source encoding and the
// helper that turns an instruction size into its low-address alignment mask.
package pc_pkg;

  typedef enum logic [2:0] {
    SEQ = 3'd0,
    BR  = 3'd1,
    J   = 3'd2,
    JR  = 3'd3,
    EXC = 3'd4
  } pc_src_e;

  localparam int MAX_ADDR_W = 64;

  // Bits that must be zero in an instruction address; inst_bytes is a power of two.
  function automatic logic [MAX_ADDR_W-1:0] align_mask(input int inst_bytes);
    return MAX_ADDR_W'(inst_bytes - 1);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer that overwrites its oldest entry when full.
// Push/pop/clear take effect on the next edge; top/count/empty reflect current state.
module ras_stack #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         pc_clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [ADDR_W-1:0]            push_data,
  output logic [ADDR_W-1:0]            top,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         empty
);

  localparam int PW = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     top_idx;
  logic [PW:0]       cnt;

  // wr_ptr names the next free slot, so the top sits one below it.
  assign top_idx = wr_ptr - PW'(1);
  assign top     = mem[top_idx];
  assign count   = cnt;
  assign empty   = (cnt == '0);

  always_ff @(posedge pc_clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge pc_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (cnt != (PW+1)'(RAS_DEPTH)) begin
        cnt <= cnt + (PW+1)'(1);
      end
    end else if (pop && !empty) begin
      wr_ptr <= top_idx;
      cnt    <= cnt - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: priority mux exc > jr > j > br > seq, one-cycle redirect latency.
// stall holds PC, RAS and pc_src (only an exception gets through); pulses clear while held.
module pc_gen
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int                INST_BYTES = 4,
  parameter int                RAS_DEPTH  = 4
) (
  input  logic                        pc_clk,
  input  logic                        rst_n,
  input  logic                        stall,
  input  logic                        br_valid,
  input  logic [ADDR_W-1:0]           br_target,
  input  logic                        j_valid,
  input  logic [ADDR_W-1:0]           j_target,
  input  logic                        j_link,
  input  logic                        jr_valid,
  input  logic [ADDR_W-1:0]           jr_target,
  input  logic                        jr_ret,
  input  logic                        exc_valid,
  input  logic [ADDR_W-1:0]           exc_vec,
  output logic [ADDR_W-1:0]           inst_out,
  output logic [ADDR_W-1:0]           pc_seq,
  output logic [2:0]                  pc_src,
  output logic                        align_err,
  output logic                        ret_mispredict,
  output logic [$clog2(RAS_DEPTH):0]  ras_count
);

  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(align_mask(INST_BYTES));

  logic [ADDR_W-1:0] pc_q;
  pc_src_e           src_q;
  logic              align_q;
  logic              mispred_q;

  logic              take;
  pc_src_e           src_d;
  logic [ADDR_W-1:0] raw_target;
  logic [ADDR_W-1:0] next_pc;
  logic              misalign;
  logic              mispred;
  logic              ras_push;
  logic              ras_pop;
  logic              ras_clear;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;

  assign pc_seq = pc_q + ADDR_W'(INST_BYTES);

  always_comb begin
    take       = 1'b1;
    src_d      = SEQ;
    raw_target = pc_seq;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    ras_clear  = 1'b0;
    if (exc_valid) begin
      src_d      = EXC;
      raw_target = exc_vec;
      ras_clear  = 1'b1;
    end else if (stall) begin
      take = 1'b0;
    end else if (jr_valid) begin
      src_d      = JR;
      raw_target = jr_target;
      ras_pop    = jr_ret;
    end else if (j_valid) begin
      src_d      = J;
      raw_target = j_target;
      ras_push   = j_link;
    end else if (br_valid) begin
      src_d      = BR;
      raw_target = br_target;
    end
  end

  assign next_pc  = raw_target & ~LOW_MASK;
  // Only redirect targets can be misaligned; the sequential path is aligned by construction.
  assign misalign = (src_d != SEQ) && (|(raw_target & LOW_MASK));
  assign mispred  = ras_pop && (ras_empty || (ras_top != next_pc));

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .pc_clk    (pc_clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .clear     (ras_clear),
    .push_data (pc_seq),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (ras_empty)
  );

  always_ff @(posedge pc_clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_VEC;
      src_q     <= SEQ;
      align_q   <= 1'b0;
      mispred_q <= 1'b0;
    end else if (take) begin
      pc_q      <= next_pc;
      src_q     <= src_d;
      align_q   <= misalign;
      mispred_q <= mispred;
    end else begin
      align_q   <= 1'b0;
      mispred_q <= 1'b0;
    end
  end

  assign inst_out       = pc_q;
  assign pc_src         = src_q;
  assign align_err      = align_q;
  assign ret_mispredict = mispred_q;

endmodule
